// File: rtl/qsort_pkg.sv
// Shared types and constants for the bus-attached quicksort core.
package qsort_pkg;

    localparam int ARR_LEN   = 16;
    localparam int IDX_W     = 4;
    localparam int DATA_W    = 8;
    localparam int STK_DEPTH = 16;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] data_t;

    // One pending partition range on the private stack.
    typedef struct packed {
        idx_t lo;
        idx_t hi;
    } stk_entry_t;

    // Array contents restored by every reset.
    localparam data_t RESET_ARR [ARR_LEN] = '{
        8'd75, 8'd3,   8'd200, 8'd18, 8'd91, 8'd0,   8'd255, 8'd42,
        8'd7,  8'd128, 8'd64,  8'd33, 8'd150, 8'd9,  8'd99,  8'd12
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PUSH_INIT,
        ST_POP,
        ST_RD_PIVOT,
        ST_SCAN_RD,
        ST_SCAN_CMP,
        ST_SWAP_RD,
        ST_SWAP_WR,
        ST_FINAL_SWAP,
        ST_PUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/qsort_bus_core_if.sv
// Handshake plus master/slave memory bus signals of the quicksort core.
// slave  : the core's own view.
// master : the system side that starts the core and closes the bus loop.
interface qsort_bus_core_if;

    logic        start_port;
    logic        done_port;

    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;

    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic [1:0]  Mout_oe_ram;
    logic [1:0]  Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    modport slave (
        input  start_port,
        input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        input  M_Rdata_ram, M_DataRdy,
        output done_port,
        output Sout_Rdata_ram, Sout_DataRdy,
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
        output Mout_data_ram_size
    );

    modport master (
        output start_port,
        output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        output M_Rdata_ram, M_DataRdy,
        input  done_port,
        input  Sout_Rdata_ram, Sout_DataRdy,
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
        input  Mout_data_ram_size
    );

endinterface

// File: rtl/qsort_bus_mem.sv
// Two-channel slave memory holding the array being sorted.
// Each channel decodes its 7-bit address against the array window; writes
// land on the sampling edge, read data and ready follow one cycle later.
// When both channels write the same element, channel 1 wins.
module qsort_bus_mem
    import qsort_pkg::*;
#(
    parameter int MEM_ARR_BASE = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  s_oe,
    input  logic [1:0]  s_we,
    input  logic [13:0] s_addr,
    input  logic [15:0] s_wdata,
    output logic [15:0] s_rdata,
    output logic [1:0]  s_rdy
);

    localparam logic [6:0] BASE7 = 7'(MEM_ARR_BASE);

    data_t       mem_q [ARR_LEN];
    data_t       mem_d [ARR_LEN];
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  rdy_q, rdy_d;

    logic [6:0]  ch_addr [2];
    logic [6:0]  ch_off  [2];
    idx_t        ch_idx  [2];
    logic [1:0]  hit;

    // Window decode, write merge (channel 1 applied last) and read capture.
    always_comb begin
        for (int k = 0; k < ARR_LEN; k++) begin
            mem_d[k] = mem_q[k];
        end
        rdata_d = '0;
        rdy_d   = '0;
        for (int c = 0; c < 2; c++) begin
            ch_addr[c] = s_addr[c*7 +: 7];
            ch_off[c]  = ch_addr[c] - BASE7;
            ch_idx[c]  = ch_off[c][IDX_W-1:0];
            hit[c]     = (s_oe[c] | s_we[c]) && (ch_addr[c] >= BASE7) &&
                         (ch_off[c] < 7'(ARR_LEN));
            if (hit[c] && s_we[c]) begin
                mem_d[ch_idx[c]] = s_wdata[c*8 +: 8];
            end
            rdy_d[c] = hit[c];
            if (hit[c] && s_oe[c]) begin
                rdata_d[c*8 +: 8] = mem_q[ch_idx[c]];
            end
        end
    end

    // Storage and response registers; reset reloads the initial contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < ARR_LEN; k++) begin
                mem_q[k] <= RESET_ARR[k];
            end
            rdata_q <= '0;
            rdy_q   <= '0;
        end else begin
            for (int k = 0; k < ARR_LEN; k++) begin
                mem_q[k] <= mem_d[k];
            end
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
        end
    end

    assign s_rdata = rdata_q;
    assign s_rdy   = rdy_q;

endmodule

// File: rtl/qsort_bus_core.sv
// In-place iterative quicksort (Lomuto) of a 16-byte array.
// Every element access goes out on the master bus: channel 0 reads,
// channel 1 writes. The slave bus feeds the internal memory.
// Build option: QSORT_DESCENDING_EN flips the partition test so the array
// ends in descending order; bus traffic structure is unchanged.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for start_port
// PUSH_INIT   | push the whole range (0,15)
// POP         | take next range off the stack, or finish when empty
// RD_PIVOT    | read a[hi] as pivot, i=j=lo
// SCAN_RD     | read a[j]
// SCAN_CMP    | partition test; swap needed -> SWAP_RD, else advance j
// SWAP_RD     | read a[i]
// SWAP_WR     | write a[i]=a[j] (ph0) then a[j]=old a[i] (ph1), advance
// FINAL_SWAP  | read a[i] (ph0), write a[i]=pivot (ph1), a[hi]=old a[i] (ph2)
// PUSH        | push left/right sub-ranges that still hold 2+ elements
// DONE        | one-cycle done_port pulse
module qsort_bus_core
    import qsort_pkg::*;
#(
    parameter int MEM_ARR_BASE = 32,
    parameter int MEM_STK_BASE = 32
) (
    input  logic             clock,
    input  logic             reset,
    qsort_bus_core_if.slave  bus
);

    localparam logic [6:0] ARR_BASE7 = 7'(MEM_ARR_BASE);
    localparam idx_t       STK_OFF   = IDX_W'(MEM_STK_BASE);

    state_t     state_q, state_d;
    logic [1:0] ph_q, ph_d;
    idx_t       lo_q, lo_d, hi_q, hi_d, i_q, i_d, j_q, j_d;
    data_t      pivot_q, pivot_d, aj_q, aj_d, ai_q, ai_d;
    logic [4:0] sp_q, sp_d;
    stk_entry_t stk_q [STK_DEPTH];
    stk_entry_t stk_d [STK_DEPTH];

    logic       rd_req_q, rd_req_d;
    logic [6:0] rd_addr_q, rd_addr_d;
    logic       wr_req_q, wr_req_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    data_t      wr_data_q, wr_data_d;

    logic       acc_rd, acc_wr, acc_done;
    idx_t       acc_idx;
    data_t      acc_wdata;
    data_t      rdata;
    logic       take_left;
    idx_t       j_nx;
    logic [4:0] sp_top, sp_push;
    logic       push_l, push_r;

    function automatic idx_t stk_slot(input idx_t p);
        return p + STK_OFF;
    endfunction

    qsort_bus_mem #(.MEM_ARR_BASE(MEM_ARR_BASE)) u_mem (
        .clock   (clock),
        .reset   (reset),
        .s_oe    (bus.S_oe_ram),
        .s_we    (bus.S_we_ram),
        .s_addr  (bus.S_addr_ram),
        .s_wdata (bus.S_Wdata_ram),
        .s_rdata (bus.Sout_Rdata_ram),
        .s_rdy   (bus.Sout_DataRdy)
    );

    // Which bus access (if any) the current state and phase need.
    always_comb begin
        acc_rd    = 1'b0;
        acc_wr    = 1'b0;
        acc_idx   = '0;
        acc_wdata = '0;
        case (state_q)
            ST_RD_PIVOT: begin
                acc_rd  = 1'b1;
                acc_idx = hi_q;
            end
            ST_SCAN_RD: begin
                acc_rd  = 1'b1;
                acc_idx = j_q;
            end
            ST_SWAP_RD: begin
                acc_rd  = 1'b1;
                acc_idx = i_q;
            end
            ST_SWAP_WR: begin
                acc_wr    = 1'b1;
                acc_idx   = (ph_q == 2'd0) ? i_q : j_q;
                acc_wdata = (ph_q == 2'd0) ? aj_q : ai_q;
            end
            ST_FINAL_SWAP: begin
                if (i_q != hi_q) begin
                    case (ph_q)
                        2'd0: begin
                            acc_rd  = 1'b1;
                            acc_idx = i_q;
                        end
                        2'd1: begin
                            acc_wr    = 1'b1;
                            acc_idx   = i_q;
                            acc_wdata = pivot_q;
                        end
                        default: begin
                            acc_wr    = 1'b1;
                            acc_idx   = hi_q;
                            acc_wdata = ai_q;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Bus handshake and FSM next state. A new request is only raised once the
    // channel's ready has dropped, so late ready pulses from the previous
    // (held) request can never be mistaken for the new one.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        i_d       = i_q;
        j_d       = j_q;
        pivot_d   = pivot_q;
        aj_d      = aj_q;
        ai_d      = ai_q;
        sp_d      = sp_q;
        for (int k = 0; k < STK_DEPTH; k++) begin
            stk_d[k] = stk_q[k];
        end
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        acc_done  = 1'b0;
        rdata     = bus.M_Rdata_ram[7:0];
        j_nx      = j_q + 4'd1;
        sp_top    = sp_q - 5'd1;
        sp_push   = sp_q;
        push_l    = ({1'b0, i_q} > ({1'b0, lo_q} + 5'd1));
        push_r    = (({1'b0, i_q} + 5'd1) < {1'b0, hi_q});
`ifdef QSORT_DESCENDING_EN
        take_left = (aj_q >= pivot_q);
`else
        take_left = (aj_q <= pivot_q);
`endif

        if (acc_rd) begin
            if (rd_req_q) begin
                if (bus.M_DataRdy[0]) begin
                    rd_req_d = 1'b0;
                    acc_done = 1'b1;
                end
            end else if (!bus.M_DataRdy[0]) begin
                rd_req_d  = 1'b1;
                rd_addr_d = ARR_BASE7 + {3'b000, acc_idx};
            end
        end
        if (acc_wr) begin
            if (wr_req_q) begin
                if (bus.M_DataRdy[1]) begin
                    wr_req_d = 1'b0;
                    acc_done = 1'b1;
                end
            end else if (!bus.M_DataRdy[1]) begin
                wr_req_d  = 1'b1;
                wr_addr_d = ARR_BASE7 + {3'b000, acc_idx};
                wr_data_d = acc_wdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start_port) state_d = ST_PUSH_INIT;
            end
            ST_PUSH_INIT: begin
                stk_d[stk_slot(4'd0)].lo = 4'd0;
                stk_d[stk_slot(4'd0)].hi = 4'd15;
                sp_d    = 5'd1;
                state_d = ST_POP;
            end
            ST_POP: begin
                if (sp_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    sp_d    = sp_top;
                    lo_d    = stk_q[stk_slot(sp_top[3:0])].lo;
                    hi_d    = stk_q[stk_slot(sp_top[3:0])].hi;
                    state_d = ST_RD_PIVOT;
                end
            end
            ST_RD_PIVOT: begin
                if (acc_done) begin
                    pivot_d = rdata;
                    i_d     = lo_q;
                    j_d     = lo_q;
                    state_d = ST_SCAN_RD;
                end
            end
            ST_SCAN_RD: begin
                if (acc_done) begin
                    aj_d    = rdata;
                    state_d = ST_SCAN_CMP;
                end
            end
            ST_SCAN_CMP: begin
                if (take_left && (i_q != j_q)) begin
                    state_d = ST_SWAP_RD;
                end else begin
                    if (take_left) i_d = i_q + 4'd1;
                    j_d     = j_nx;
                    ph_d    = 2'd0;
                    state_d = (j_nx == hi_q) ? ST_FINAL_SWAP : ST_SCAN_RD;
                end
            end
            ST_SWAP_RD: begin
                if (acc_done) begin
                    ai_d    = rdata;
                    ph_d    = 2'd0;
                    state_d = ST_SWAP_WR;
                end
            end
            ST_SWAP_WR: begin
                if (acc_done) begin
                    if (ph_q == 2'd0) begin
                        ph_d = 2'd1;
                    end else begin
                        ph_d    = 2'd0;
                        i_d     = i_q + 4'd1;
                        j_d     = j_nx;
                        state_d = (j_nx == hi_q) ? ST_FINAL_SWAP : ST_SCAN_RD;
                    end
                end
            end
            ST_FINAL_SWAP: begin
                if (i_q == hi_q) begin
                    ph_d    = 2'd0;
                    state_d = ST_PUSH;
                end else if (acc_done) begin
                    case (ph_q)
                        2'd0: begin
                            ai_d = rdata;
                            ph_d = 2'd1;
                        end
                        2'd1: ph_d = 2'd2;
                        default: begin
                            ph_d    = 2'd0;
                            state_d = ST_PUSH;
                        end
                    endcase
                end
            end
            ST_PUSH: begin
                if (push_l) begin
                    stk_d[stk_slot(sp_push[3:0])].lo = lo_q;
                    stk_d[stk_slot(sp_push[3:0])].hi = i_q - 4'd1;
                    sp_push = sp_push + 5'd1;
                end
                if (push_r) begin
                    stk_d[stk_slot(sp_push[3:0])].lo = i_q + 4'd1;
                    stk_d[stk_slot(sp_push[3:0])].hi = hi_q;
                    sp_push = sp_push + 5'd1;
                end
                sp_d    = sp_push;
                state_d = ST_POP;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and bus request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            i_q       <= '0;
            j_q       <= '0;
            pivot_q   <= '0;
            aj_q      <= '0;
            ai_q      <= '0;
            sp_q      <= '0;
            for (int k = 0; k < STK_DEPTH; k++) begin
                stk_q[k] <= '0;
            end
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            i_q       <= i_d;
            j_q       <= j_d;
            pivot_q   <= pivot_d;
            aj_q      <= aj_d;
            ai_q      <= ai_d;
            sp_q      <= sp_d;
            for (int k = 0; k < STK_DEPTH; k++) begin
                stk_q[k] <= stk_d[k];
            end
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Master lanes are zero whenever the channel has no request pending.
    always_comb begin
        bus.Mout_oe_ram        = {1'b0, rd_req_q};
        bus.Mout_we_ram        = {wr_req_q, 1'b0};
        bus.Mout_addr_ram      = {(wr_req_q ? wr_addr_q : 7'd0),
                                  (rd_req_q ? rd_addr_q : 7'd0)};
        bus.Mout_Wdata_ram     = {(wr_req_q ? wr_data_q : 8'd0), 8'd0};
        bus.Mout_data_ram_size = {(wr_req_q ? 4'd8 : 4'd0),
                                  (rd_req_q ? 4'd8 : 4'd0)};
        bus.done_port          = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_qsort_bus_core.sv
// Directed bench for qsort_bus_core: loops the master bus into the slave bus
// (optionally with one extra cycle of ready/data delay) and checks sorting,
// reset behaviour, start handling and slave window decoding.
module tb_qsort_bus_core;

    logic clk;
    logic rst;

    qsort_bus_core_if bus();

    qsort_bus_core #(.MEM_ARR_BASE(32), .MEM_STK_BASE(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic        start_r;
    logic        tb_drive;
    logic        dly;
    logic [1:0]  t_oe, t_we;
    logic [13:0] t_addr;
    logic [15:0] t_wdata;
    logic [7:0]  t_size;
    logic [15:0] d_rdata;
    logic [1:0]  d_rdy;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;
    int cyc_fast, cyc_slow, cyc_tmp, base;

    logic [7:0] exp_reset [16] = '{8'd75, 8'd3, 8'd200, 8'd18, 8'd91, 8'd0, 8'd255, 8'd42,
                                   8'd7, 8'd128, 8'd64, 8'd33, 8'd150, 8'd9, 8'd99, 8'd12};
`ifdef QSORT_DESCENDING_EN
    logic [7:0] exp_sorted [16] = '{8'd255, 8'd200, 8'd150, 8'd128, 8'd99, 8'd91, 8'd75, 8'd64,
                                    8'd42, 8'd33, 8'd18, 8'd12, 8'd9, 8'd7, 8'd3, 8'd0};
`else
    logic [7:0] exp_sorted [16] = '{8'd0, 8'd3, 8'd7, 8'd9, 8'd12, 8'd18, 8'd33, 8'd42,
                                    8'd64, 8'd75, 8'd91, 8'd99, 8'd128, 8'd150, 8'd200, 8'd255};
`endif

    assign bus.start_port      = start_r;
    assign bus.S_oe_ram        = tb_drive ? t_oe    : bus.Mout_oe_ram;
    assign bus.S_we_ram        = tb_drive ? t_we    : bus.Mout_we_ram;
    assign bus.S_addr_ram      = tb_drive ? t_addr  : bus.Mout_addr_ram;
    assign bus.S_Wdata_ram     = tb_drive ? t_wdata : bus.Mout_Wdata_ram;
    assign bus.S_data_ram_size = tb_drive ? t_size  : bus.Mout_data_ram_size;
    assign bus.M_Rdata_ram     = dly ? d_rdata : bus.Sout_Rdata_ram;
    assign bus.M_DataRdy       = dly ? d_rdy   : bus.Sout_DataRdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            d_rdata <= '0;
            d_rdy   <= '0;
        end else begin
            d_rdata <= bus.Sout_Rdata_ram;
            d_rdy   <= bus.Sout_DataRdy;
        end
    end

    always @(negedge clk) begin
        if (bus.done_port === 1'b1) done_cnt++;
        if ((bus.Mout_oe_ram & bus.Mout_we_ram) != 2'b00) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic slave_acc(input logic [1:0] oe, input logic [1:0] we,
                             input logic [13:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rdata, output logic [1:0] rdy);
        @(negedge clk);
        tb_drive = 1'b1;
        t_oe     = oe;
        t_we     = we;
        t_addr   = addr;
        t_wdata  = wdata;
        t_size   = {(oe[1] | we[1]) ? 4'd8 : 4'd0, (oe[0] | we[0]) ? 4'd8 : 4'd0};
        @(negedge clk);
        rdata = bus.Sout_Rdata_ram;
        rdy   = bus.Sout_DataRdy;
        t_oe  = '0;
        t_we  = '0;
        t_size = '0;
    endtask

    task automatic check_array(input string tag, input logic [7:0] exp [16]);
        logic [15:0] rd;
        logic [1:0]  rdy;
        logic [6:0]  a7;
        logic [7:0]  lane;
        logic        rbit;
        for (int k = 0; k < 16; k++) begin
            a7 = 7'(32 + k);
            if (k[0]) begin
                slave_acc(2'b10, 2'b00, {a7, 7'd0}, 16'd0, rd, rdy);
                lane = rd[15:8];
                rbit = rdy[1];
            end else begin
                slave_acc(2'b01, 2'b00, {7'd0, a7}, 16'd0, rd, rdy);
                lane = rd[7:0];
                rbit = rdy[0];
            end
            check($sformatf("%s[%0d]", tag, k), {23'd0, rbit, lane}, {23'd0, 1'b1, exp[k]});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        tb_drive = 1'b0;
        start_r  = 1'b1;
        @(negedge clk);
        start_r  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int b, output int cyc);
        cyc = 0;
        while (done_cnt == b && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (40) @(posedge clk);
        check(tag, done_cnt - b, 1);
    endtask

    initial begin
        logic [15:0] rd;
        logic [1:0]  rdy;
        start_r  = 1'b0;
        tb_drive = 1'b1;
        dly      = 1'b0;
        t_oe     = '0;
        t_we     = '0;
        t_addr   = '0;
        t_wdata  = '0;
        t_size   = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_done", {31'd0, bus.done_port}, 0);
        check("rst_mout_oe_we", {28'd0, bus.Mout_oe_ram, bus.Mout_we_ram}, 0);
        check("rst_mout_addr", {18'd0, bus.Mout_addr_ram}, 0);
        check("rst_mout_size", {24'd0, bus.Mout_data_ram_size}, 0);
        check("rst_sout_rdy", {30'd0, bus.Sout_DataRdy}, 0);
        rst = 1'b0;
        @(negedge clk);

        check_array("reset_arr", exp_reset);

        base = done_cnt;
        pulse_start();
        wait_done("done_fast", base, cyc_fast);
        check_array("sorted_fast", exp_sorted);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dly = 1'b1;
        base = done_cnt;
        pulse_start();
        wait_done("done_slow", base, cyc_slow);
        check("slow_cycles_grow", {31'd0, cyc_slow > cyc_fast}, 1);
        check("oe_we_overlap", overlap_cnt, 0);
        check_array("sorted_slow", exp_sorted);
        dly = 1'b0;

        slave_acc(2'b11, 2'b00, {7'd48, 7'd31}, 16'd0, rd, rdy);
        check("oow_read_data", {16'd0, rd}, 0);
        check("oow_read_rdy", {30'd0, rdy}, 0);
        slave_acc(2'b00, 2'b11, {7'd31, 7'd48}, 16'hAAAA, rd, rdy);
        check("oow_write_rdy", {30'd0, rdy}, 0);
        check_array("after_oow_write", exp_sorted);

        base = done_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mout", {28'd0, bus.Mout_oe_ram, bus.Mout_we_ram}, 0);
        check("midrst_sout_rdy", {30'd0, bus.Sout_DataRdy}, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);
        check_array("midrst_arr", exp_reset);
        base = done_cnt;
        pulse_start();
        wait_done("done_after_midrst", base, cyc_tmp);
        check_array("sorted_after_midrst", exp_sorted);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = done_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        wait_done("done_busy_start", base, cyc_tmp);
        base = done_cnt;
        pulse_start();
        wait_done("done_resort", base, cyc_tmp);
        check_array("resorted", exp_sorted);

        slave_acc(2'b00, 2'b11, {7'd40, 7'd40}, 16'h2211, rd, rdy);
        check("dual_write_rdy", {30'd0, rdy}, 3);
        slave_acc(2'b01, 2'b00, {7'd0, 7'd40}, 16'd0, rd, rdy);
        check("dual_write_ch1_wins", {24'd0, rd[7:0]}, 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
